// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky HALT and ERR traps.
// Define C_EXT_EN to latch inst_is_c with the IR and report a 2-byte PC increment for it.
module multicycle_ctrl #(
  parameter int unsigned MEM_TO_MAX = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic        inst_is_c,
  input  logic        mem_ready,
  output logic        fetch_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic        branch,
  output logic        memtoreg,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic [1:0]  jump,
  output logic [2:0]  pc_inc,
  output logic        halted,
  output logic        mem_err,
  output logic        illegal,
  output logic [2:0]  state
);

  if (MEM_TO_MAX < 1 || MEM_TO_MAX >= (1 << CNT_W)) begin : gen_bad_param
    $error("multicycle_ctrl: MEM_TO_MAX must be in [1, 2**CNT_W - 1]");
  end

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StErr    = 3'd6
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIArith = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TO_MAX - 1);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             mem_err_q, mem_err_d;
  logic             illegal_q, illegal_d;

  // Opcode decode of the captured instruction.
  logic [6:0] opcode;
  logic is_r, is_iarith, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_system;
  logic is_legal, is_ebreak, wb_en;

  assign opcode    = ir_q[6:0];
  assign is_r      = (opcode == OpR);
  assign is_iarith = (opcode == OpIArith);
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);
  assign is_lui    = (opcode == OpLui);
  assign is_auipc  = (opcode == OpAuipc);
  assign is_system = (opcode == OpSystem);
  assign is_legal  = is_r | is_iarith | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc | is_system;
  assign is_ebreak = is_system & ir_q[20];
  assign wb_en     = is_r | is_iarith | is_load | is_jal | is_jalr | is_lui | is_auipc;

  logic unused_ir;
  assign unused_ir = ^{ir_q[31:21], ir_q[19:7]};

`ifdef C_EXT_EN
  logic c_q, c_d;
`endif

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    mem_err_d = mem_err_q;
    illegal_d = illegal_q;
`ifdef C_EXT_EN
    c_d       = c_q;
`endif
    fetch_req = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;

    unique case (state_q)
      StFetch: begin
        fetch_req = 1'b1;
        if (inst_valid) begin
          ir_we   = 1'b1;
          ir_d    = inst;
`ifdef C_EXT_EN
          c_d     = inst_is_c;
`endif
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_ebreak) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else if (!is_legal) begin
          state_d   = StErr;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_load || is_store) begin
          state_d = StMem;
          cnt_d   = '0;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        memread  = is_load;
        memwrite = is_store;
        // A completion on the timeout cycle wins over the error.
        if (mem_ready) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_d   = StErr;
            mem_err_d = 1'b1;
          end
        end
      end
      StWb: begin
        regwrite = wb_en;
        pc_we    = 1'b1;
        state_d  = StFetch;
      end
      StHalt, StErr: begin
        state_d = state_q;
      end
      default: begin
        state_d = StErr;
      end
    endcase

    // Strobes are suppressed while reset is held so nothing leaks out of an aborted access.
    if (!rst) begin
      fetch_req = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      regwrite  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef C_EXT_EN
      c_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
      illegal_q <= illegal_d;
`ifdef C_EXT_EN
      c_q       <= c_d;
`endif
    end
  end

  // Static decode fields; forced to zero while fetching since the IR is stale there.
  always_comb begin
    aluop    = 2'b00;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    jump     = 2'b00;
    if (state_q != StFetch) begin
      if (is_r || is_iarith) begin
        aluop = 2'b10;
      end else if (is_branch || is_lui) begin
        aluop = 2'b01;
      end
      alusrc   = !(is_r || is_branch || is_system);
      memtoreg = is_load;
      branch   = is_branch;
      if (is_jal) begin
        jump = 2'b01;
      end else if (is_jalr) begin
        jump = 2'b10;
      end
    end
  end

`ifdef C_EXT_EN
  assign pc_inc = c_q ? 3'd2 : 3'd4;
`else
  logic unused_inst_is_c;
  assign unused_inst_is_c = inst_is_c;
  assign pc_inc = 3'd4;
`endif

  assign halted  = halted_q;
  assign mem_err = mem_err_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected strobe events, a monitor
// pops and compares one entry whenever any strobe other than fetch_req is high.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_is_c;
  logic        mem_ready;
  logic        fetch_req, ir_we, pc_we, memread, memwrite, regwrite;
  logic        branch, memtoreg, alusrc;
  logic [1:0]  aluop, jump;
  logic [2:0]  pc_inc;
  logic        halted, mem_err, illegal;
  logic [2:0]  state;

  multicycle_ctrl #(.MEM_TO_MAX(15), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_is_c  (inst_is_c),
    .mem_ready  (mem_ready),
    .fetch_req  (fetch_req),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .memread    (memread),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .branch     (branch),
    .memtoreg   (memtoreg),
    .alusrc     (alusrc),
    .aluop      (aluop),
    .jump       (jump),
    .pc_inc     (pc_inc),
    .halted     (halted),
    .mem_err    (mem_err),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe vector order: {ir_we, pc_we, regwrite, memread, memwrite}
  localparam logic [4:0] SIr = 5'b10000;
  localparam logic [4:0] SPc = 5'b01000;
  localparam logic [4:0] SRw = 5'b00100;
  localparam logic [4:0] SMr = 5'b00010;
  localparam logic [4:0] SMw = 5'b00001;

`ifdef C_EXT_EN
  localparam logic [2:0] PciC = 3'd2;
`else
  localparam logic [2:0] PciC = 3'd4;
`endif

  typedef struct {
    string      nm;
    int         cy;
    logic [2:0] st;
    logic [4:0] strb;
    logic [6:0] fld;   // {aluop, alusrc, memtoreg, branch, jump}
    logic [2:0] pci;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [6:0] f(logic [1:0] aop, logic asrc, logic m2r, logic br,
                                   logic [1:0] jmp);
    return {aop, asrc, m2r, br, jmp};
  endfunction

  task automatic push(string nm, int cy, logic [2:0] st, logic [4:0] strb, logic [6:0] fld,
                      logic [2:0] pci);
    exp_t e;
    e.nm   = nm;
    e.cy   = cy;
    e.st   = st;
    e.strb = strb;
    e.fld  = fld;
    e.pci  = pci;
    exp_q.push_back(e);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every non-fetch strobe event must match the head of the scoreboard.
  exp_t       me;
  logic [4:0] ms;
  logic [6:0] mf;
  always @(negedge clk) begin
    ms = {ir_we, pc_we, regwrite, memread, memwrite};
    mf = {aluop, alusrc, memtoreg, branch, jump};
    if (ms != 5'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d state=%0d strobes=%b required=none",
                 cyc, state, ms);
      end else begin
        me = exp_q.pop_front();
        if (cyc != me.cy || state !== me.st || ms !== me.strb || mf !== me.fld ||
            (me.strb[3] && pc_inc !== me.pci)) begin
          failures++;
          $display({"FAIL %s actual cyc=%0d state=%0d strobes=%b fields=%b pc_inc=%0d ",
                    "required cyc=%0d state=%0d strobes=%b fields=%b pc_inc=%0d"},
                   me.nm, cyc, state, ms, mf, pc_inc, me.cy, me.st, me.strb, me.fld, me.pci);
        end
      end
    end
  end

  // kind: 0 = writeback path, 1 = branch, 2 = load, 3 = store; waits = mem_ready=0 cycles.
  task automatic run_inst(string nm, logic [31:0] ins, int kind, int waits, logic [6:0] fld,
                          logic rw, logic isc);
    int         c0;
    logic [2:0] pci;
    c0  = cyc;
    pci = isc ? PciC : 3'd4;
    inst       = ins;
    inst_valid = 1'b1;
    inst_is_c  = isc;
    push({nm, "_fetch"}, c0, 3'd0, SIr, 7'b0, 3'd4);
    case (kind)
      0: push({nm, "_wb"}, c0 + 3, 3'd4, SPc | (rw ? SRw : 5'b0), fld, pci);
      1: push({nm, "_exec"}, c0 + 2, 3'd2, SPc, fld, pci);
      2: begin
        for (int i = 0; i <= waits; i++) push({nm, "_mem"}, c0 + 3 + i, 3'd3, SMr, fld, pci);
        push({nm, "_wb"}, c0 + 4 + waits, 3'd4, SPc | SRw, fld, pci);
      end
      default: begin
        for (int i = 0; i <= waits; i++)
          push({nm, "_mem"}, c0 + 3 + i, 3'd3, SMw | ((i == waits) ? SPc : 5'b0), fld, pci);
      end
    endcase
    tick(1);
    inst_is_c = 1'b0;
    if (kind != 0) inst_valid = 1'b0;
    case (kind)
      0: begin
        tick(2);
        inst_valid = 1'b0;
        tick(1);
      end
      1: tick(2);
      default: begin
        tick(2);
        for (int i = 0; i <= waits; i++) begin
          mem_ready = (i == waits);
          tick(1);
        end
        mem_ready = 1'b0;
        if (kind == 2) tick(1);
      end
    endcase
    chk({nm, "_back_in_fetch"}, {29'b0, state}, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst        = 1'b0;
    inst       = 32'h0;
    inst_valid = 1'b0;
    inst_is_c  = 1'b0;
    mem_ready  = 1'b0;
    tick(2);
    chk("reset_state", {29'b0, state}, 32'd0);
    chk("reset_flags", {29'b0, halted, mem_err, illegal}, 32'd0);
    chk("reset_fetch_req_held", {31'b0, fetch_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("fetch_req_after_reset", {31'b0, fetch_req}, 32'd1);

    run_inst("add",   32'h003100B3, 0, 0,  f(2'b10, 1'b0, 1'b0, 1'b0, 2'b00), 1'b1, 1'b0);
    run_inst("addi",  32'h00500093, 0, 0,  f(2'b10, 1'b1, 1'b0, 1'b0, 2'b00), 1'b1, 1'b1);
    run_inst("beq",   32'h00000463, 1, 0,  f(2'b01, 1'b0, 1'b0, 1'b1, 2'b00), 1'b0, 1'b0);
    run_inst("lw_w3", 32'h0000A083, 2, 3,  f(2'b00, 1'b1, 1'b1, 1'b0, 2'b00), 1'b1, 1'b0);
    chk("lw_no_mem_err", {31'b0, mem_err}, 32'd0);
    run_inst("lw_w0", 32'h0000A083, 2, 0,  f(2'b00, 1'b1, 1'b1, 1'b0, 2'b00), 1'b1, 1'b0);
    run_inst("sw_w0", 32'h00112023, 3, 0,  f(2'b00, 1'b1, 1'b0, 1'b0, 2'b00), 1'b0, 1'b0);
    run_inst("sw_w14", 32'h00112023, 3, 14, f(2'b00, 1'b1, 1'b0, 1'b0, 2'b00), 1'b0, 1'b0);
    chk("sw_tiebreak_no_err", {31'b0, mem_err}, 32'd0);
    run_inst("jal",   32'h000000EF, 0, 0,  f(2'b00, 1'b1, 1'b0, 1'b0, 2'b01), 1'b1, 1'b0);
    run_inst("jalr",  32'h00008067, 0, 0,  f(2'b00, 1'b1, 1'b0, 1'b0, 2'b10), 1'b1, 1'b0);
    run_inst("lui",   32'h123450B7, 0, 0,  f(2'b01, 1'b1, 1'b0, 1'b0, 2'b00), 1'b1, 1'b0);
    run_inst("auipc", 32'h00000097, 0, 0,  f(2'b00, 1'b1, 1'b0, 1'b0, 2'b00), 1'b1, 1'b0);
    run_inst("ecall", 32'h00000073, 0, 0,  f(2'b00, 1'b0, 1'b0, 1'b0, 2'b00), 1'b0, 1'b0);

    // Store with the memory never answering: 15 MEM cycles, then the error trap.
    c0 = cyc;
    inst = 32'h00112023;
    inst_valid = 1'b1;
    push("sw_to_fetch", c0, 3'd0, SIr, 7'b0, 3'd4);
    for (int i = 0; i < 15; i++)
      push("sw_to_mem", c0 + 3 + i, 3'd3, SMw, f(2'b00, 1'b1, 1'b0, 1'b0, 2'b00), 3'd4);
    tick(1);
    inst_valid = 1'b0;
    tick(17);
    chk("sw_to_state_err", {29'b0, state}, 32'd6);
    chk("sw_to_mem_err", {31'b0, mem_err}, 32'd1);
    chk("sw_to_illegal_clear", {31'b0, illegal}, 32'd0);
    chk("sw_to_strobes_off",
        {26'b0, fetch_req, ir_we, pc_we, regwrite, memread, memwrite}, 32'd0);
    inst_valid = 1'b1;
    tick(3);
    chk("err_absorbing", {29'b0, state}, 32'd6);
    inst_valid = 1'b0;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    chk("err_reset_state", {29'b0, state}, 32'd0);
    chk("err_reset_mem_err", {31'b0, mem_err}, 32'd0);

    // Reset landing in the middle of a store access.
    c0 = cyc;
    inst = 32'h00112023;
    inst_valid = 1'b1;
    push("sw_rst_fetch", c0, 3'd0, SIr, 7'b0, 3'd4);
    push("sw_rst_mem0", c0 + 3, 3'd3, SMw, f(2'b00, 1'b1, 1'b0, 1'b0, 2'b00), 3'd4);
    push("sw_rst_mem1", c0 + 4, 3'd3, SMw, f(2'b00, 1'b1, 1'b0, 1'b0, 2'b00), 3'd4);
    tick(1);
    inst_valid = 1'b0;
    tick(4);
    rst = 1'b0;
    #1;
    chk("sw_rst_memwrite_during", {31'b0, memwrite}, 32'd0);
    tick(1);
    rst = 1'b1;
    #1;
    chk("sw_rst_state", {29'b0, state}, 32'd0);
    chk("sw_rst_memwrite_after", {31'b0, memwrite}, 32'd0);
    tick(1);

    // EBREAK halts and ignores further fetch data until reset.
    c0 = cyc;
    inst = 32'h00100073;
    inst_valid = 1'b1;
    push("ebreak_fetch", c0, 3'd0, SIr, 7'b0, 3'd4);
    tick(1);
    inst_valid = 1'b0;
    tick(1);
    chk("ebreak_state", {29'b0, state}, 32'd5);
    chk("ebreak_halted", {31'b0, halted}, 32'd1);
    inst_valid = 1'b1;
    tick(3);
    chk("halt_no_fetch_req", {31'b0, fetch_req}, 32'd0);
    chk("halt_absorbing", {29'b0, state}, 32'd5);
    inst_valid = 1'b0;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    chk("halt_reset_state", {29'b0, state}, 32'd0);
    chk("halt_reset_fetch_req", {31'b0, fetch_req}, 32'd1);
    chk("halt_reset_halted", {31'b0, halted}, 32'd0);

    // Opcode 0000000 is illegal.
    c0 = cyc;
    inst = 32'h00000000;
    inst_valid = 1'b1;
    push("illegal_fetch", c0, 3'd0, SIr, 7'b0, 3'd4);
    tick(1);
    inst_valid = 1'b0;
    tick(1);
    chk("illegal_state", {29'b0, state}, 32'd6);
    chk("illegal_flag", {31'b0, illegal}, 32'd1);
    chk("illegal_no_mem_err", {31'b0, mem_err}, 32'd0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
